// File: rtl/sm3_expnd_core_wrapper_spec.sv
// SM3 message expansion stage: collects one 16-word padded block, then streams
// the 64 (Wj, W'j) pairs to the compression stage through a sliding 16-word window.
module sm3_expnd_core_wrapper_spec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pad_otpt_d,
  input  logic        pad_otpt_vld,
  input  logic        pad_otpt_lst,
  output logic        pad_otpt_ena,
  input  logic        expnd_otpt_ena,
  output logic [31:0] expnd_otpt_wj,
  output logic [31:0] expnd_otpt_wjj,
  output logic        expnd_otpt_vld,
  output logic        expnd_otpt_lst,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where the producer's valid
  // and the consumer's ready/enable are both high; valid never depends on ready.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EXPND = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [3:0]  wcnt_q, wcnt_d;
  logic [5:0]  j_q, j_d;
  logic        last_q, last_d;

  logic        word_acc;
  logic        pair_xfer;
  logic [31:0] p1_in;
  logic [31:0] w_new;

  function automatic logic [31:0] rotl7(input logic [31:0] x);
    return {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] rotl15(input logic [31:0] x);
    return {x[16:0], x[31:17]};
  endfunction

  function automatic logic [31:0] rotl23(input logic [31:0] x);
    return {x[8:0], x[31:9]};
  endfunction

  assign word_acc  = pad_otpt_vld & pad_otpt_ena;
  assign pair_xfer = expnd_otpt_vld & expnd_otpt_ena;

  // Window slot 0 is W[j]; the new word W[j+16] enters at slot 15.
  assign p1_in = win_q[0] ^ win_q[7] ^ rotl15(win_q[13]);
  assign w_new = p1_in ^ rotl15(p1_in) ^ rotl23(p1_in) ^ rotl7(win_q[3]) ^ win_q[10];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (word_acc) state_d = ST_LOAD;
      ST_LOAD:  if (word_acc && (wcnt_q == 4'd15)) state_d = ST_EXPND;
      ST_EXPND: if (pair_xfer && (j_q == 6'd63)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pad_otpt_ena   = (state_q != ST_EXPND);
    expnd_otpt_vld = (state_q == ST_EXPND);
    expnd_otpt_lst = (state_q == ST_EXPND) & (j_q == 6'd63) & last_q;
    expnd_otpt_wj  = win_q[0];
    expnd_otpt_wjj = win_q[0] ^ win_q[4];
    dbg_state      = state_q;
  end

  // Window, counters and last-block flag. Loading and expanding share the same
  // shift so that after 16 loads slot 0 holds word 0 of the block.
  always_comb begin
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    wcnt_d = wcnt_q;
    j_d    = j_q;
    last_d = last_q;
    if (word_acc) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = pad_otpt_d;
      wcnt_d    = wcnt_q + 4'd1;
      if (wcnt_q == 4'd15) last_d = pad_otpt_lst;
    end else if (pair_xfer) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = w_new;
      j_d       = j_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
      wcnt_q <= 4'd0;
      j_q    <= 6'd0;
      last_q <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
      wcnt_q <= wcnt_d;
      j_q    <= j_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_sm3_expnd_core_wrapper_spec.sv
// Directed bench for the SM3 expansion stage: known-answer 'abc' block, uniform
// block, two-block message, stalls, input gaps and resets in LOAD/EXPND.
module tb_sm3_expnd_core_wrapper_spec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pad_otpt_d;
  logic        pad_otpt_vld;
  logic        pad_otpt_lst;
  logic        pad_otpt_ena;
  logic        expnd_otpt_ena;
  logic [31:0] expnd_otpt_wj;
  logic [31:0] expnd_otpt_wjj;
  logic        expnd_otpt_vld;
  logic        expnd_otpt_lst;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [31:0] blk     [16];
  logic [31:0] blk2    [16];
  logic [31:0] got_wj  [64];
  logic [31:0] got_wjj [64];

  sm3_expnd_core_wrapper_spec dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pad_otpt_d     (pad_otpt_d),
    .pad_otpt_vld   (pad_otpt_vld),
    .pad_otpt_lst   (pad_otpt_lst),
    .pad_otpt_ena   (pad_otpt_ena),
    .expnd_otpt_ena (expnd_otpt_ena),
    .expnd_otpt_wj  (expnd_otpt_wj),
    .expnd_otpt_wjj (expnd_otpt_wjj),
    .expnd_otpt_vld (expnd_otpt_vld),
    .expnd_otpt_lst (expnd_otpt_lst),
    .dbg_state      (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference expansion of blk, written with absolute indices.
  task automatic model_block();
    logic [31:0] w [68];
    logic [31:0] x;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 68; i++) begin
      x    = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
      w[i] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(w[i-13], 7) ^ w[i-6];
    end
    for (int j = 0; j < 64; j++) exp_q.push_back({w[j], w[j] ^ w[j+4]});
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  // Driver: offer one word (after an optional idle gap) until it is accepted.
  task automatic push_word(input logic [31:0] d, input logic l, input bit gaps);
    int gap;
    int t;
    bit acc;
    gap = gaps ? int'($urandom_range(0, 3)) : 0;
    if (gap > 0) begin
      pad_otpt_vld = 1'b0;
      pad_otpt_d   = $urandom;
      pad_otpt_lst = 1'($urandom_range(0, 1));
      repeat (gap) @(posedge clk);
      #1;
    end
    pad_otpt_vld = 1'b1;
    pad_otpt_d   = d;
    pad_otpt_lst = l;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = pad_otpt_ena;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("accept_timeout", 64'(t), 64'(0));
  endtask

  task automatic load_block(input int first, input logic l, input bit gaps,
                            input bit hold, input logic [31:0] nxt);
    for (int i = first; i < 16; i++) push_word(blk[i], (i == 15) ? l : 1'b0, gaps);
    pad_otpt_lst = 1'b0;
    if (hold) begin
      pad_otpt_vld = 1'b1;
      pad_otpt_d   = nxt;
    end else begin
      pad_otpt_vld = 1'b0;
    end
  endtask

  // Scoreboard: check every cycle of EXPND against the front of exp_q.
  task automatic drain(input int n, input bit rnd, input logic last);
    int j;
    int cycles;
    logic [63:0] e;
    j      = 0;
    cycles = 0;
    while (j < n) begin
      if (cycles > 2000) begin
        chk("drain_timeout", 64'(j), 64'(n));
        break;
      end
      expnd_otpt_ena = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
      chk("expnd_vld", 64'(expnd_otpt_vld), 64'(1));
      chk("expnd_wj", 64'(expnd_otpt_wj), 64'(e[63:32]));
      chk("expnd_wjj", 64'(expnd_otpt_wjj), 64'(e[31:0]));
      chk("expnd_lst", 64'(expnd_otpt_lst), 64'(last && (j == 63)));
      chk("pad_ena_low", 64'(pad_otpt_ena), 64'(0));
      if (expnd_otpt_ena) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got_wj[j]  = expnd_otpt_wj;
        got_wjj[j] = expnd_otpt_wjj;
        j++;
      end
      cycles++;
      @(posedge clk);
      #1;
    end
    if (n == 64) begin
      if (!rnd) chk("expnd_cycles", 64'(cycles), 64'(64));
      @(negedge clk);
      chk("post_vld", 64'(expnd_otpt_vld), 64'(0));
      chk("post_pad_ena", 64'(pad_otpt_ena), 64'(1));
      chk("post_state", 64'(dbg_state), 64'(0));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_abc();
    chk("abc_w0", 64'(got_wj[0]), 64'(32'h61626380));
    chk("abc_wp0", 64'(got_wjj[0]), 64'(32'h61626380));
    chk("abc_w16", 64'(got_wj[16]), 64'(32'h9092E200));
    chk("abc_w18", 64'(got_wj[18]), 64'(32'h000C0606));
    chk("abc_w19", 64'(got_wj[19]), 64'(32'h719C70ED));
    chk("abc_wp12", 64'(got_wjj[12]), 64'(32'h9092E200));
    chk("abc_wp15", 64'(got_wjj[15]), 64'(32'h719C70F5));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld"}, 64'(expnd_otpt_vld), 64'(0));
    chk({tag, "_lst"}, 64'(expnd_otpt_lst), 64'(0));
    chk({tag, "_wj"}, 64'(expnd_otpt_wj), 64'(0));
    chk({tag, "_wjj"}, 64'(expnd_otpt_wjj), 64'(0));
    chk({tag, "_pad_ena"}, 64'(pad_otpt_ena), 64'(1));
    chk({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  initial begin
    // Reset
    rst_n          = 1'b0;
    pad_otpt_d     = 32'h0;
    pad_otpt_vld   = 1'b0;
    pad_otpt_lst   = 1'b0;
    expnd_otpt_ena = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 'abc' known-answer block
    set_abc();
    model_block();
    load_block(0, 1'b1, 1'b0, 1'b0, 32'h0);
    drain(64, 1'b0, 1'b1);
    check_abc();

    // Sixteen identical words, not last
    for (int i = 0; i < 16; i++) blk[i] = 32'h61626364;
    model_block();
    load_block(0, 1'b0, 1'b0, 1'b0, 32'h0);
    drain(64, 1'b0, 1'b0);
    for (int j = 0; j < 12; j++) chk("uniform_wp", 64'(got_wjj[j]), 64'(0));

    // Two-block message; block-2 word 0 waits through block-1 expansion
    for (int i = 0; i < 16; i++) begin
      blk[i]  = $urandom;
      blk2[i] = $urandom;
    end
    model_block();
    load_block(0, 1'b0, 1'b0, 1'b1, blk2[0]);
    drain(64, 1'b0, 1'b0);
    chk("blk2_word0_taken", 64'(dbg_state), 64'(1));
    for (int i = 0; i < 16; i++) blk[i] = blk2[i];
    model_block();
    load_block(1, 1'b1, 1'b0, 1'b0, 32'h0);
    drain(64, 1'b0, 1'b1);

    // Input gaps during LOAD and random stalls during EXPND
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    model_block();
    load_block(0, 1'b1, 1'b1, 1'b0, 32'h0);
    drain(64, 1'b1, 1'b1);

    // Random stalls on the 'abc' block reproduce the known answers
    set_abc();
    model_block();
    load_block(0, 1'b1, 1'b1, 1'b0, 32'h0);
    drain(64, 1'b1, 1'b1);
    check_abc();

    // Reset in EXPND at j=30
    set_abc();
    model_block();
    load_block(0, 1'b1, 1'b0, 1'b0, 32'h0);
    drain(30, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_expnd");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_expnd_no_pair", 64'(expnd_otpt_vld), 64'(0));
    @(posedge clk);
    #1;
    model_block();
    load_block(0, 1'b1, 1'b0, 1'b0, 32'h0);
    drain(64, 1'b0, 1'b1);
    check_abc();

    // Reset in LOAD after 8 words discards the partial block
    for (int i = 0; i < 8; i++) push_word($urandom, 1'b1, 1'b0);
    pad_otpt_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_load");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_abc();
    model_block();
    load_block(0, 1'b1, 1'b0, 1'b0, 32'h0);
    drain(64, 1'b0, 1'b1);
    check_abc();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
